// File: rtl/simon_decrypt.sv
// simon_decrypt: iterative SIMON decryption, one round per clock, with a single-entry round-key cache
`ifndef N
`define N 16
`endif
`ifndef M
`define M 4
`endif
module simon_decrypt #(
  parameter int n = `N,
  parameter int m = `M
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2*n-1:0] ciphertext,
  input  logic [n*m-1:0] key,
  output logic [2*n-1:0] plaintext,
  output logic           done,
  output logic           busy
);
  localparam int T = n == 16 ? 32 : n == 24 ? 36 : m == 3 ? 42 : 44;
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z = (n == 16 || (n == 24 && m == 3)) ? Z0 : n == 24 ? Z1 : m == 3 ? Z2 : Z3;
  localparam logic [n-1:0] C3 = n'(3);
  if (!((n == 16 && m == 4) || ((n == 24 || n == 32) && (m == 3 || m == 4)))) begin : g_bad
    $error("simon_decrypt: unsupported (n,m) pair");
  end
  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [n-1:0] x, y, ktmp, knew, btmp, kprev, ynew;
  logic [m-1:0][n-1:0] w, cw;
  logic [n*m-1:0] kr, ck;
  logic cv, accept, hit, kexp_last, dec_last;
  function automatic logic [n-1:0] rol(input logic [n-1:0] a, input int s);
    return (a << s) | (a >> (n - s));
  endfunction
  // z-sequence bit i, counted from the first symbol; out-of-range steps are don't-care
  function automatic logic [n-1:0] zw(input int i);
    return {{(n-1){1'b0}}, (i >= 0 && i < 62) ? Z[61-i] : 1'b0};
  endfunction
  assign accept    = en && (state == IDLE || state == DONE);
  assign hit       = cv && key == ck;
  assign kexp_last = state == KEXP && cnt == 6'(T - m - 1);
  assign dec_last  = state == DEC && cnt == 6'(T - 1);
  // forward key step, backward key step and the inverse round
  always_comb begin
    ktmp  = rol(w[m-1], n - 3) ^ (m == 4 ? w[1] : '0);
    ktmp  = ktmp ^ rol(ktmp, n - 1);
    knew  = ~w[0] ^ ktmp ^ zw(int'(cnt)) ^ C3;
    btmp  = rol(w[m-2], n - 3) ^ (m == 4 ? w[0] : '0);
    btmp  = btmp ^ rol(btmp, n - 1);
    kprev = w[m-1] ^ ~C3 ^ zw(T - 1 - m - int'(cnt)) ^ btmp;
    ynew  = x ^ ((rol(y, 1) & rol(y, 8)) ^ rol(y, 2)) ^ w[m-1];
  end
  // next-state selection
  always_comb begin
    state_nx = accept ? (hit ? DEC : KEXP) : kexp_last ? DEC : dec_last ? DONE : state;
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  // datapath, key window, cache and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      plaintext <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cv        <= 1'b0;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      w         <= '0;
      cw        <= '0;
      kr        <= '0;
      ck        <= '0;
    end else if (accept) begin
      {x, y} <= ciphertext;
      kr     <= key;
      done   <= 1'b0;
      busy   <= 1'b1;
      cnt    <= '0;
      w      <= hit ? cw : key;
    end else if (state == KEXP) begin
      w   <= {knew, w[m-1:1]};
      cnt <= kexp_last ? '0 : cnt + 6'd1;
      if (kexp_last) begin
        cw <= {knew, w[m-1:1]};
        ck <= kr;
        cv <= 1'b1;
      end
    end else if (state == DEC) begin
      {x, y} <= {y, ynew};
      w      <= {w[m-2:0], kprev};
      cnt    <= cnt + 6'd1;
      if (dec_last) begin
        plaintext <= {y, ynew};
        done      <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end
endmodule
